// File: rtl/lnic_pkg.sv
// Shared types for the NIC network-side flit path: flit layout and the ingress buffer FSM states.
package lnic_pkg;

    localparam int unsigned NET_DATA_BITS = 64;
    localparam int unsigned NET_KEEP_BITS = 8;

    typedef struct packed {
        logic [NET_DATA_BITS-1:0] data;
        logic [NET_KEEP_BITS-1:0] keep;
        logic                     last;
    } net_flit_t;

    typedef enum logic {
        RX_ACCEPT = 1'b0,
        RX_DROP   = 1'b1
    } rx_state_e;

endpackage

// File: rtl/lnic_net_rx_ram.sv
// Flit storage for the ingress buffer: one synchronous write port, one asynchronous read port.
module lnic_net_rx_ram
    import lnic_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  net_flit_t                      i_wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output net_flit_t                      o_rdata
);

    net_flit_t r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lnic_net_rx_buffer.sv
// Store-and-forward ingress buffer: commits whole packets from the backpressure-free network
// stream, drops oversize/overflowing packets, and presents committed flits on valid/ready.
module lnic_net_rx_buffer
    import lnic_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 512,
    parameter int unsigned MAX_PKT_WORDS = 190
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           net_in_valid,
    input  logic [NET_DATA_BITS-1:0]       net_in_bits_data,
    input  logic [NET_KEEP_BITS-1:0]       net_in_bits_keep,
    input  logic                           net_in_bits_last,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [NET_DATA_BITS-1:0]       out_bits_data,
    output logic [NET_KEEP_BITS-1:0]       out_bits_keep,
    output logic                           out_bits_last,
    output logic [31:0]                    drop_count,
    output logic [$clog2(DEPTH_WORDS):0]   words_used
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);
    localparam logic [CW-1:0] MAX_P   = CW'(MAX_PKT_WORDS);

    rx_state_e     r_state, w_state_nxt;
    logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [PW-1:0] r_commit_ptr, w_commit_ptr_nxt;
    logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [CW-1:0] r_pkt_words, w_pkt_words_nxt;
    logic [31:0]   r_drop_count, w_drop_count_nxt;
    logic          w_full;
    logic          w_pop;
    logic          w_we;
    net_flit_t     w_wr_flit;
    net_flit_t     w_rd_flit;

    // Full is judged on the registered read pointer, so a same-cycle pop never makes room.
    assign w_full    = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign out_valid = r_rd_ptr != r_commit_ptr;
    assign w_pop     = out_valid & out_ready;
    assign w_wr_flit = '{data: net_in_bits_data, keep: net_in_bits_keep, last: net_in_bits_last};

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_pkt_words_nxt  = r_pkt_words;
        w_drop_count_nxt = r_drop_count;
        w_we             = 1'b0;

        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end

        case (r_state)
            RX_ACCEPT: begin
                if (net_in_valid) begin
                    if (!w_full && (r_pkt_words < MAX_P)) begin
                        w_we            = 1'b1;
                        w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
                        w_pkt_words_nxt = r_pkt_words + 1'b1;
                        if (net_in_bits_last) begin
                            w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                            w_pkt_words_nxt  = '0;
                        end
                    end else begin
                        // Roll back the partial packet; the rest of it is swallowed in RX_DROP.
                        w_wr_ptr_nxt    = r_commit_ptr;
                        w_pkt_words_nxt = '0;
                        if (r_drop_count != '1) begin
                            w_drop_count_nxt = r_drop_count + 1'b1;
                        end
                        if (!net_in_bits_last) begin
                            w_state_nxt = RX_DROP;
                        end
                    end
                end
            end
            RX_DROP: begin
                if (net_in_valid && net_in_bits_last) begin
                    w_state_nxt = RX_ACCEPT;
                end
            end
            default: w_state_nxt = RX_ACCEPT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RX_ACCEPT;
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_wr_ptr     <= '0;
            r_pkt_words  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_pkt_words  <= w_pkt_words_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    lnic_net_rx_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wr_flit),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rd_flit)
    );

    assign out_bits_data = w_rd_flit.data;
    assign out_bits_keep = w_rd_flit.keep;
    assign out_bits_last = w_rd_flit.last;
    assign drop_count    = r_drop_count;
    assign words_used    = r_commit_ptr - r_rd_ptr;

endmodule

// File: tb/tb_lnic_net_rx_buffer.sv
// Scoreboard bench for lnic_net_rx_buffer: three instances (depth 512, 8, 16) share one stimulus bus.
module tb_lnic_net_rx_buffer;
    import lnic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_keep = '0;
    logic        in_last = 1'b0;
    logic        ready = 1'b0;
    bit          skip = 1'b0;

    logic        ov [3];
    logic [63:0] od [3];
    logic [7:0]  ok [3];
    logic        ol [3];
    logic [31:0] dc [3];
    logic [9:0]  wu0;
    logic [3:0]  wu1;
    logic [4:0]  wu2;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned delivered = 0;
    net_flit_t   q[$];

    always #5 clk = ~clk;

    lnic_net_rx_buffer #(.DEPTH_WORDS(512), .MAX_PKT_WORDS(190)) u_big (
        .clock(clk), .reset(rst), .net_in_valid(in_valid && sel == 2'd0),
        .net_in_bits_data(in_data), .net_in_bits_keep(in_keep), .net_in_bits_last(in_last),
        .out_ready(ready && sel == 2'd0), .out_valid(ov[0]), .out_bits_data(od[0]),
        .out_bits_keep(ok[0]), .out_bits_last(ol[0]), .drop_count(dc[0]), .words_used(wu0));

    lnic_net_rx_buffer #(.DEPTH_WORDS(8), .MAX_PKT_WORDS(190)) u_d8 (
        .clock(clk), .reset(rst), .net_in_valid(in_valid && sel == 2'd1),
        .net_in_bits_data(in_data), .net_in_bits_keep(in_keep), .net_in_bits_last(in_last),
        .out_ready(ready && sel == 2'd1), .out_valid(ov[1]), .out_bits_data(od[1]),
        .out_bits_keep(ok[1]), .out_bits_last(ol[1]), .drop_count(dc[1]), .words_used(wu1));

    lnic_net_rx_buffer #(.DEPTH_WORDS(16), .MAX_PKT_WORDS(190)) u_d16 (
        .clock(clk), .reset(rst), .net_in_valid(in_valid && sel == 2'd2),
        .net_in_bits_data(in_data), .net_in_bits_keep(in_keep), .net_in_bits_last(in_last),
        .out_ready(ready && sel == 2'd2), .out_valid(ov[2]), .out_bits_data(od[2]),
        .out_bits_keep(ok[2]), .out_bits_last(ol[2]), .drop_count(dc[2]), .words_used(wu2));

    logic        ov_s;
    logic [31:0] dc_s;
    logic [9:0]  wu_s;
    net_flit_t   flit_s;
    assign ov_s   = ov[sel];
    assign dc_s   = dc[sel];
    assign wu_s   = (sel == 2'd0) ? wu0 : (sel == 2'd1) ? 10'(wu1) : 10'(wu2);
    assign flit_s = '{data: od[sel], keep: ok[sel], last: ol[sel]};

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted output flit and checks stability while stalled.
    net_flit_t prev_flit;
    bit        prev_hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", {22'b0, ov_s, flit_s}, {22'b0, 1'b1, prev_flit});
            if (ov_s && ready) begin
                if (skip) begin
                    while (q.size() > 0 && q[0].data != flit_s.data) void'(q.pop_front());
                end
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %0h expected none", flit_s);
                end else begin
                    chk("out_flit", {23'b0, flit_s}, {23'b0, q.pop_front()});
                    delivered++;
                end
            end
            prev_hold = ov_s && !ready;
            prev_flit = flit_s;
        end
    end

    task automatic do_reset(input logic [1:0] k);
        rst = 1'b1; sel = k; in_valid = 1'b0; ready = 1'b0; skip = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        delivered = 0;
        chk("reset_out_valid", 96'(ov_s), 96'(0));
        chk("reset_words_used", 96'(wu_s), 96'(0));
        chk("reset_drop_count", 96'(dc_s), 96'(0));
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input bit exp);
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        if (exp) q.push_back('{data: d, keep: k, last: l});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string nm, input bit want_empty);
        int unsigned n = 0;
        ready = 1'b1;
        while (ov_s && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        if (ov_s) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout: got out_valid 1 expected 0", nm);
        end
        if (want_empty) chk({nm, "_leftover"}, 96'(q.size()), 96'(0));
    endtask

    initial begin
        // 1: 3-flit packet, out_valid the cycle after the last flit.
        do_reset(2'd0);
        ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b1);
        send(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0, 1'b1);
        chk("t1_valid_before_commit", 96'(ov_s), 96'(0));
        send(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1, 1'b1);
        chk("t1_valid_after_commit", 96'(ov_s), 96'(1));
        chk("t1_words_used_peak", 96'(wu_s), 96'(3));
        drain("t1", 1'b1);
        chk("t1_drop_count", 96'(dc_s), 96'(0));

        // 2: depth 8, no reads; second 5-flit packet overflows on its 4th flit.
        do_reset(2'd1);
        for (int i = 0; i < 5; i++) send(64'hA000 + 64'(i), 8'(8'h11 << (i % 4)), i == 4, 1'b1);
        for (int i = 0; i < 5; i++) send(64'hB000 + 64'(i), 8'hFF, i == 4, 1'b0);
        chk("t2_drop_count", 96'(dc_s), 96'(1));
        chk("t2_words_used", 96'(wu_s), 96'(5));
        drain("t2", 1'b1);

        // 3: 191-flit packet dropped, then 2-flit and 190-flit packets accepted.
        do_reset(2'd0);
        ready = 1'b1;
        for (int i = 0; i < 191; i++) send(64'hE000_0000 + 64'(i), 8'hFF, i == 190, 1'b0);
        send(64'h2222_0000, 8'h01, 1'b0, 1'b1);
        send(64'h2222_0001, 8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 190; i++) send(64'hC000_0000 + 64'(i), 8'(i), i == 189, 1'b1);
        drain("t3", 1'b1);
        chk("t3_drop_count", 96'(dc_s), 96'(1));

        // 4: depth 16, 10k back-to-back 1-flit packets, random out_ready.
        do_reset(2'd2);
        skip = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            ready = 1'($urandom_range(0, 1));
            send(64'hD000_0000_0000_0000 + 64'(i), 8'(i * 3), 1'b1, 1'b1);
        end
        drain("t4", 1'b0);
        chk("t4_delivered_plus_drops", 96'(delivered + dc_s), 96'(10000));

        // 5: reset between flit 2 and flit 3; flit 4 then arrives as a fresh 1-flit packet.
        do_reset(2'd0);
        ready = 1'b1;
        send(64'h5555_0001, 8'hFF, 1'b0, 1'b0);
        send(64'h5555_0002, 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        send(64'h5555_0003, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t5_out_valid", 96'(ov_s), 96'(0));
        chk("t5_words_used", 96'(wu_s), 96'(0));
        chk("t5_drop_count", 96'(dc_s), 96'(0));
        send(64'h5555_0004, 8'h3C, 1'b1, 1'b1);
        drain("t5", 1'b1);

        // 6: depth 8 near full; pop+write at full-1 accepted, pop+write at full dropped.
        do_reset(2'd1);
        for (int i = 1; i <= 7; i++) send(64'h6600 + 64'(i), 8'(i), 1'b1, 1'b1);
        chk("t6_words_used_full_m1", 96'(wu_s), 96'(7));
        ready = 1'b1;
        send(64'h6608, 8'h08, 1'b1, 1'b1);
        ready = 1'b0;
        chk("t6_drop_after_pop_write", 96'(dc_s), 96'(0));
        send(64'h6609, 8'h09, 1'b1, 1'b1);
        chk("t6_words_used_full", 96'(wu_s), 96'(8));
        ready = 1'b1;
        send(64'h660A, 8'h0A, 1'b1, 1'b0);
        ready = 1'b0;
        chk("t6_drop_at_full_with_pop", 96'(dc_s), 96'(1));
        send(64'h660B, 8'h0B, 1'b1, 1'b1);
        chk("t6_words_used_end", 96'(wu_s), 96'(8));
        drain("t6", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
